// File: rtl/rv_bus_xbar.sv
// rv_bus_xbar: one LSU master to N slaves with base/mask address decode, an in-order
// response-tracking FIFO, generated errors for unmapped addresses and a head watchdog.
module rv_bus_xbar #(
    parameter int                XLEN     = 32,
    parameter int                N_SLAVES = 3,
    parameter int                DEPTH    = 2,
    parameter logic [XLEN-1:0]   SLAVE_BASE [N_SLAVES] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0010},
    parameter logic [XLEN-1:0]   SLAVE_MASK [N_SLAVES] = '{32'hFFFF_C000, 32'hFFFF_FFF0, 32'hFFFF_FFF0},
    parameter int                TIMEOUT  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          data_req_i,
    input  logic                          data_we_i,
    input  logic [XLEN/8-1:0]             data_be_i,
    input  logic [XLEN-1:0]               data_addr_i,
    input  logic [XLEN-1:0]               data_wdata_i,
    output logic                          data_gnt_o,
    output logic                          data_rvalid_o,
    output logic [XLEN-1:0]               data_rdata_o,
    output logic                          data_err_o,
    output logic [N_SLAVES-1:0]           slv_req_o,
    output logic                          slv_we_o,
    output logic [XLEN/8-1:0]             slv_be_o,
    output logic [XLEN-1:0]               slv_addr_o,
    output logic [XLEN-1:0]               slv_wdata_o,
    input  logic [N_SLAVES-1:0]           slv_rvalid_i,
    input  logic [N_SLAVES-1:0][XLEN-1:0] slv_rdata_i,
    output logic                          spurious_o
);

    localparam int IDX_W = $clog2(N_SLAVES + 1);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // The extra index past the last slave tags requests that decoded to nothing.
    localparam logic [IDX_W-1:0] ERR     = IDX_W'(N_SLAVES);
    localparam logic [CW-1:0]    WAIT_TO = CW'(TIMEOUT);

    logic [IDX_W-1:0] sel;
    logic [XLEN-1:0]  sel_mask;
    logic             mapped;
    logic             push;
    logic             pop;

    logic [IDX_W-1:0] fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] level;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             full;
    logic             empty;

    logic [IDX_W-1:0] head;
    logic             head_live;
    logic             head_rvalid;
    logic [XLEN-1:0]  head_rdata;
    logic [N_SLAVES-1:0] expected_rvalid;

    logic [CW-1:0]    wait_cnt_q;
    logic [CW-1:0]    wait_cnt_d;
    logic             timeout_hit;

    // Decode: walking from the top down lets the lowest-index hit overwrite the rest.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel      = ERR;
        sel_mask = '1;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((data_addr_i & SLAVE_MASK[k]) == SLAVE_BASE[k]) begin
                sel      = IDX_W'(k);
                sel_mask = SLAVE_MASK[k];
            end
        end
    end

    assign mapped     = (sel != ERR);
    assign data_gnt_o = data_req_i & ~full & ~rst_i;
    assign push       = data_gnt_o;

    always_comb begin
        slv_req_o = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            slv_req_o[k] = push && mapped && (sel == IDX_W'(k));
        end
    end

    assign slv_we_o    = data_we_i;
    assign slv_be_o    = data_be_i;
    assign slv_wdata_o = data_wdata_i;
    assign slv_addr_o  = data_addr_i & ~sel_mask;

    // Tracking FIFO: pointers carry one wrap bit so full and empty fall out of the difference.
    assign level  = wr_ptr_q - rd_ptr_q;
    assign full   = (level == PTR_W'(DEPTH));
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign wr_idx = AW'(wr_ptr_q % PTR_W'(DEPTH));
    assign rd_idx = AW'(rd_ptr_q % PTR_W'(DEPTH));
    assign head   = fifo_q[rd_idx];

    assign head_live = !empty && (head != ERR);

    always_comb begin
        head_rvalid     = 1'b0;
        head_rdata      = '0;
        expected_rvalid = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (head == IDX_W'(k)) begin
                head_rvalid = slv_rvalid_i[k];
                head_rdata  = slv_rdata_i[k];
            end
            expected_rvalid[k] = head_live && (head == IDX_W'(k));
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && !empty && (wait_cnt_q == WAIT_TO);

    // Response priority at the head: generated unmapped error, real response, watchdog error.
    always_comb begin
        data_rvalid_o = 1'b0;
        data_rdata_o  = '0;
        data_err_o    = 1'b0;
        pop           = 1'b0;
        if (!rst_i && !empty) begin
            if (head == ERR) begin
                data_rvalid_o = 1'b1;
                data_err_o    = 1'b1;
                pop           = 1'b1;
            end else if (head_rvalid) begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = head_rdata;
                pop           = 1'b1;
            end else if (timeout_hit) begin
                data_rvalid_o = 1'b1;
                data_err_o    = 1'b1;
                pop           = 1'b1;
            end
        end
    end

    assign spurious_o = !rst_i && |(slv_rvalid_i & ~expected_rvalid);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (pop || empty || (TIMEOUT == 0)) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_TO) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // NOTE: the entry storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_idx] <= sel;
        end
    end

    a_req_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(slv_req_o));
    a_level_bound : assert property (@(posedge clk_i) disable iff (rst_i) level <= PTR_W'(DEPTH));

endmodule

// File: tb/tb_rv_bus_xbar.sv
// Bench for rv_bus_xbar: a queue-based reference model checked every cycle on the falling
// edge, plus directed scenarios with hand-computed literal expectations.
module tb_rv_bus_xbar;

    localparam int N       = 3;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 16;
    localparam logic [31:0] BASE [N] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0010};
    localparam logic [31:0] MASK [N] = '{32'hFFFF_C000, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [3:0]        be = 4'h0;
    logic [31:0]       addr = 32'h0;
    logic [31:0]       wdata = 32'h0;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;
    logic [N-1:0]      slv_req;
    logic              slv_we;
    logic [3:0]        slv_be;
    logic [31:0]       slv_addr;
    logic [31:0]       slv_wdata;
    logic [N-1:0]      srv = '0;
    logic [N-1:0][31:0] srd = '0;
    logic              spurious;

    always #5 clk = ~clk;

    rv_bus_xbar #(
        .XLEN(32), .N_SLAVES(N), .DEPTH(DEPTH),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req), .data_we_i(we), .data_be_i(be),
        .data_addr_i(addr), .data_wdata_i(wdata),
        .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
        .slv_req_o(slv_req), .slv_we_o(slv_we), .slv_be_o(slv_be),
        .slv_addr_o(slv_addr), .slv_wdata_o(slv_wdata),
        .slv_rvalid_i(srv), .slv_rdata_i(srd),
        .spurious_o(spurious)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < N; k++) begin
            if ((a & MASK[k]) == BASE[k]) return k;
        end
        return N;
    endfunction

    // Reference model: the queue holds the target of every outstanding request in grant order,
    // and age counts the cycles the current head has waited.
    int          q[$];
    int          age = 0;
    int          m_sel;
    int          m_head;
    logic        e_gnt, e_rv, e_err, e_sp;
    logic [31:0] e_rd;
    logic [N-1:0] e_req;

    always @(negedge clk) begin
        if (rst) begin
            check("m_gnt_in_reset", gnt, 0);
            check("m_slv_req_in_reset", slv_req, 0);
            q.delete();
            age = 0;
        end else begin
            m_sel = decode(addr);
            e_gnt = req && (q.size() < DEPTH);
            e_req = (e_gnt && m_sel < N) ? N'(1 << m_sel) : '0;
            e_rv  = 1'b0;
            e_err = 1'b0;
            e_rd  = 32'h0;
            m_head = -1;
            if (q.size() > 0) begin
                m_head = q[0];
                if (m_head == N) begin
                    e_rv = 1'b1; e_err = 1'b1;
                end else if (srv[m_head]) begin
                    e_rv = 1'b1; e_rd = srd[m_head];
                end else if (TIMEOUT != 0 && age == TIMEOUT) begin
                    e_rv = 1'b1; e_err = 1'b1;
                end
            end
            e_sp = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (srv[k] && k != m_head) e_sp = 1'b1;
            end

            check("m_gnt", gnt, e_gnt);
            check("m_slv_req", slv_req, e_req);
            if (e_req != 0) begin
                check("m_slv_addr", slv_addr, addr & ~MASK[m_sel]);
                check("m_slv_we", slv_we, we);
                check("m_slv_be", slv_be, be);
                check("m_slv_wdata", slv_wdata, wdata);
            end
            check("m_rvalid", rvalid, e_rv);
            check("m_spurious", spurious, e_sp);
            if (e_rv) begin
                check("m_err", err, e_err);
                check("m_rdata", rdata, e_rd);
            end

            if (e_rv) begin
                void'(q.pop_front());
                age = 0;
            end else if (q.size() > 0 && age < TIMEOUT) begin
                age++;
            end
            if (e_gnt) q.push_back(m_sel);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a);
        req   = r;
        we    = w;
        be    = r ? 4'hF : 4'h0;
        addr  = a;
        wdata = a ^ 32'h5A5A_0000;
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_spurious"}, spurious, 0);
        check({tag, "_slv_req"}, slv_req, 0);
        check({tag, "_rdata"}, rdata, 0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #2 reset_values("rst");
        cyc();

        // SRAM read answered the next cycle
        drive(1, 0, 32'h0000_0104);
        #2 check("t1_slv_req", slv_req, 3'b001);
        check("t1_slv_addr", slv_addr, 32'h0000_0104);
        check("t1_gnt", gnt, 1);
        cyc();
        drive(0, 0, 0);
        srv = 3'b001; srd[0] = 32'hDEAD_BEEF;
        #2 check("t1_rvalid", rvalid, 1);
        check("t1_rdata", rdata, 32'hDEAD_BEEF);
        check("t1_err", err, 0);
        cyc();
        srv = '0;
        cyc();

        // HEX write then KEY read; out-of-order KEY response is spurious
        drive(1, 1, 32'h8000_0000);
        #2 check("t2_hex_req", slv_req, 3'b010);
        check("t2_hex_addr", slv_addr, 32'h0);
        cyc();
        drive(1, 0, 32'h8000_0014);
        #2 check("t2_key_req", slv_req, 3'b100);
        check("t2_key_addr", slv_addr, 32'h4);
        cyc();
        drive(0, 0, 0);
        srv = 3'b100; srd[2] = 32'h7;
        #2 check("t2_early_spurious", spurious, 1);
        check("t2_early_rvalid", rvalid, 0);
        cyc();
        srv = 3'b010; srd[1] = 32'h1234;
        #2 check("t2_hex_rvalid", rvalid, 1);
        check("t2_hex_rdata", rdata, 32'h1234);
        check("t2_hex_spurious", spurious, 0);
        cyc();
        srv = 3'b100; srd[2] = 32'h5;
        #2 check("t2_key_rvalid", rvalid, 1);
        check("t2_key_rdata", rdata, 32'h5);
        check("t2_key_err", err, 0);
        cyc();
        srv = '0;
        cyc();

        // Unmapped address
        drive(1, 0, 32'h4000_0000);
        #2 check("t3_slv_req", slv_req, 3'b000);
        check("t3_gnt", gnt, 1);
        cyc();
        drive(0, 0, 0);
        #2 check("t3_rvalid", rvalid, 1);
        check("t3_rdata", rdata, 0);
        check("t3_err", err, 1);
        cyc();

        // FIFO full: third request stalls until the cycle after the first pop
        drive(1, 0, 32'h0000_0100);
        #2 check("t4_gnt0", gnt, 1);
        cyc();
        drive(1, 0, 32'h8000_0000);
        #2 check("t4_gnt1", gnt, 1);
        cyc();
        drive(1, 0, 32'h8000_0010);
        #2 check("t4_gnt2", gnt, 0);
        check("t4_req2", slv_req, 3'b000);
        cyc();
        srv = 3'b001; srd[0] = 32'h0000_0AAA;
        #2 check("t4_pop_rvalid", rvalid, 1);
        check("t4_no_bypass", gnt, 0);
        cyc();
        srv = '0;
        #2 check("t4_gnt_back", gnt, 1);
        check("t4_req_back", slv_req, 3'b100);
        cyc();
        drive(0, 0, 0);
        srv = 3'b010; srd[1] = 32'h11;
        #2 check("t4_hex_rdata", rdata, 32'h11);
        cyc();
        srv = 3'b100; srd[2] = 32'h22;
        #2 check("t4_key_rdata", rdata, 32'h22);
        cyc();
        srv = '0;
        cyc();

        // Watchdog: SRAM never answers
        drive(1, 0, 32'h0000_0200);
        cyc();
        drive(0, 0, 0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            #2 check("t5_waiting", rvalid, 0);
            cyc();
        end
        #2 check("t5_to_rvalid", rvalid, 1);
        check("t5_to_err", err, 1);
        check("t5_to_rdata", rdata, 0);
        cyc();
        cyc();
        cyc();
        srv = 3'b001; srd[0] = 32'h0BAD_0BAD;
        #2 check("t5_late_spurious", spurious, 1);
        check("t5_late_rvalid", rvalid, 0);
        cyc();
        srv = '0;
        cyc();

        // Reset with two outstanding requests
        drive(1, 0, 32'h0000_0300);
        cyc();
        drive(1, 1, 32'h8000_0004);
        cyc();
        drive(0, 0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #2 reset_values("t6_rst");
        cyc();
        srv = 3'b011; srd[0] = 32'h1; srd[1] = 32'h2;
        #2 check("t6_spurious", spurious, 1);
        check("t6_rvalid", rvalid, 0);
        cyc();
        srv = '0;
        cyc();

        // Streaming: push and pop every cycle keeps one entry outstanding
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 32'h0000_0400 + 32'(4 * i));
            srv = (i > 0) ? 3'b001 : 3'b000;
            srd[0] = 32'(i);
            #2 check("t7_gnt", gnt, 1);
            if (i > 0) check("t7_rdata", rdata, 32'(i));
            cyc();
        end
        drive(0, 0, 0);
        srv = 3'b001; srd[0] = 32'h99;
        #2 check("t7_last", rdata, 32'h99);
        cyc();
        srv = '0;
        cyc();

        // Unmapped error queued behind a pending SRAM read
        drive(1, 0, 32'h0000_0500);
        cyc();
        drive(1, 0, 32'h4000_0000);
        #2 check("t8_gnt_unmapped", gnt, 1);
        cyc();
        drive(0, 0, 0);
        srv = 3'b001; srd[0] = 32'h0000_5555;
        #2 check("t8_sram_rdata", rdata, 32'h0000_5555);
        check("t8_sram_err", err, 0);
        cyc();
        srv = '0;
        #2 check("t8_err_rvalid", rvalid, 1);
        check("t8_err", err, 1);
        cyc();
        #2 check("t8_drained", rvalid, 0);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_bus_xbar.md
# rv_bus_xbar

Parametrised 1-master / N-slave data-bus interconnect placed between the core's LSU data port and the memory/peripheral slaves (SRAM, HEX, KEY, …). It decodes each request against a per-slave base/mask table and forwards it, with a slave-local address, to exactly one slave. A DEPTH-entry in-order tracking FIFO routes every response back to the master. Unmapped addresses get a generated error response, and a per-request watchdog answers hung slaves with an error.

## Interface
- N_SLAVES, 3, number of slave ports (1..8)
- DEPTH, 2, max outstanding requests (power of 2, ≥1)
- SLAVE_BASE, {32'h0000_0000, 32'h8000_0000, 32'h8000_0010}, per-slave base address [N_SLAVES][XLEN]
- SLAVE_MASK, {32'hFFFF_C000, 32'hFFFF_FFF0, 32'hFFFF_FFF0}, per-slave match mask [N_SLAVES][XLEN]
- TIMEOUT, 16, cycles a head request may wait for its response; 0 disables watchdog
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- data_req_i  in  1  master request
- data_we_i  in  1  write enable
- data_be_i  in  XLEN/8  byte enables
- data_addr_i  in  XLEN  global byte address
- data_wdata_i  in  XLEN  write data
- data_gnt_o  out  1  request accepted this cycle
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  XLEN  response data
- data_err_o  out  1  response is an error (qualified by data_rvalid_o)
- slv_req_o  out  N_SLAVES  one-hot slave request
- slv_we_o / slv_be_o / slv_wdata_o  out  1 / XLEN/8 / XLEN  shared copies of master fields
- slv_addr_o  out  XLEN  local address = data_addr_i & ~SLAVE_MASK[sel]
- slv_rvalid_i  in  N_SLAVES  per-slave response valid
- slv_rdata_i  in  N_SLAVES×XLEN  per-slave response data
- spurious_o  out  1  pulse: rvalid from a slave not at FIFO head

## Operation
- Decode: slave k hits when (data_addr_i & SLAVE_MASK[k]) == SLAVE_BASE[k]. The lowest-index hit wins. No hit means unmapped; index ERR = N_SLAVES is used.
- data_gnt_o = data_req_i & ~full & ~rst_i. It does not bypass on same-cycle pop.
- On grant of a mapped request, slv_req_o[sel] = 1, combinationally in the same cycle. Unmapped: slv_req_o = 0.
- On grant, the target index (ERR for unmapped) is pushed into the tracking FIFO. Every granted request, read or write, receives exactly one response, in grant order.
- Head entry is a real slave h:
  - When slv_rvalid_i[h] = 1: data_rvalid_o = 1, data_rdata_o = slv_rdata_i[h], data_err_o = 0, pop. This path is combinational pass-through.
- Head entry is ERR:
  - In its first cycle at head: data_rvalid_o = 1, data_rdata_o = 0, data_err_o = 1, pop.
- Watchdog: wait_cnt counts cycles the head is valid without a response. It clears on pop and saturates at TIMEOUT.
  - If wait_cnt == TIMEOUT (TIMEOUT ≠ 0) and the head slave's rvalid is low, an error response (rdata 0, err 1) is issued and the entry is popped.
  - A real rvalid in that same cycle wins over the error.
- slv_rvalid_i[k] with k ≠ head slave, or with FIFO empty, is ignored. It pulses spurious_o for that cycle, and FIFO and counter are unaffected. A late response from a timed-out slave behaves exactly this way.
- Push and pop in the same cycle are both applied; count is unchanged. Push while full is impossible, because gnt is low when full.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. full and empty are derived from the pointers.

## Timing
- Reset values (cycle after rst_i sampled high): FIFO empty, wait_cnt = 0. data_rvalid_o, data_err_o, spurious_o, slv_req_o and data_gnt_o are all 0, and data_rdata_o = 0.
- Reset mid-transaction drops all outstanding entries. Responses arriving afterwards raise spurious_o only.
- Request path is combinational, 0 cycles: decode → slv_req_o / data_gnt_o / slv_addr_o.
- Response latency for a request granted in cycle t:
  - Earliest slave response at t+1, passed through in the same cycle.
  - Unmapped error at t+1 if the FIFO was empty, otherwise in the cycle after the prior head pops.
  - Watchdog error in the (TIMEOUT+1)-th cycle of the entry at head.
- Throughput: 1 request/cycle while not full, and 1 response/cycle.

## Test plan
- Read at 0x0000_0104, SRAM answers next cycle with 0xDEADBEEF -> slv_req_o = 3'b001 and slv_addr_o = 0x104 at t; at t+1 data_rvalid_o = 1, rdata 0xDEADBEEF, err 0.
- Write 0x8000_0000 then read 0x8000_0014 back-to-back, HEX responds at t+3 and KEY at t+2 -> KEY response flagged spurious_o and ignored. HEX response is forwarded at t+3. Then KEY re-responds with 0x5 at t+4 -> forwarded, err 0.
- Request to 0x4000_0000 (unmapped) -> slv_req_o = 0, gnt = 1; at t+1 rvalid = 1, rdata 0, err 1.
- DEPTH = 2, three consecutive requests with slaves silent -> gnt = 1,1,0. gnt returns to 1 in the cycle after the first pop.
- TIMEOUT = 16, SRAM never answers -> error response in cycle t+17, then FIFO empty. An SRAM rvalid at t+20 -> spurious_o pulse only.
- rst_i asserted with 2 outstanding -> next cycle all outputs are at reset values. Slave rvalid afterwards -> spurious_o = 1, data_rvalid_o = 0.
